// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, requester state encoding and the APB4
// write-strobe rule. Reused by the responders on the same peripheral bus.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Reads must present an all-zero strobe on APB4.
  function automatic logic [APB_STRB_W-1:0] apb_pstrb(
    input logic                  write,
    input logic [APB_STRB_W-1:0] wstrb
  );
    return write ? wstrb : '0;
  endfunction

endpackage

// File: rtl/apb_req_bridge_if.sv
// Bundles for the requester: CPU-side request/response channel and the APB4
// bus. Master drives requests, slave answers them.
interface apb_req_bridge_if;
  import apb_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [APB_ADDR_W-1:0] req_addr;
  logic                  req_write;
  logic [APB_DATA_W-1:0] req_wdata;
  logic [APB_STRB_W-1:0] req_wstrb;
  logic [2:0]            req_prot;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface apb_if;
  import apb_pkg::*;

  logic [APB_ADDR_W-1:0] out_paddr;
  logic                  out_psel;
  logic                  out_penable;
  logic [2:0]            out_pprot;
  logic                  out_pwrite;
  logic [APB_DATA_W-1:0] out_pwdata;
  logic [APB_STRB_W-1:0] out_pstrb;
  logic                  out_pready;
  logic [APB_DATA_W-1:0] out_prdata;
  logic                  out_pslverr;

  modport master (
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    input  out_pready, out_prdata, out_pslverr
  );

  modport slave (
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    output out_pready, out_prdata, out_pslverr
  );
endinterface

// File: rtl/apb_req_bridge.sv
// APB4 requester: turns one outstanding valid/ready request into a SETUP/ACCESS
// transfer, with a bounded ACCESS wait so a stuck responder cannot hang the CPU.
module apb_req_bridge
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset,
  apb_req_bridge_if.slave req,
  apb_if.master           apb
);

  localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  apb_state_e            state_q;
  logic [APB_ADDR_W-1:0] addr_q;
  logic                  write_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [APB_STRB_W-1:0] wstrb_q;
  logic [2:0]            prot_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rsp_valid_q;
  logic [APB_DATA_W-1:0] rdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  timeout_hit;

  always_comb begin
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LIMIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      prot_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req.req_valid) begin
            addr_q  <= req.req_addr;
            write_q <= req.req_write;
            wdata_q <= req.req_wdata;
            wstrb_q <= req.req_wstrb;
            prot_q  <= req.req_prot;
            psel_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apb.out_pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            err_q       <= apb.out_pslverr;
            // Writes and errored reads return zero data.
            rdata_q     <= (write_q || apb.out_pslverr) ? '0 : apb.out_prdata;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b1;
            rdata_q     <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (req.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset masks the ready decode so nothing is offered while reset is held.
  assign req.req_ready = (state_q == IDLE) && !reset;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_rdata = rdata_q;
  assign req.rsp_err   = err_q;

  assign apb.out_paddr   = addr_q;
  assign apb.out_psel    = psel_q;
  assign apb.out_penable = penable_q;
  assign apb.out_pprot   = prot_q;
  assign apb.out_pwrite  = write_q;
  assign apb.out_pwdata  = wdata_q;
  assign apb.out_pstrb   = apb_pstrb(write_q, wstrb_q);

endmodule

// File: tb/tb_apb_req_bridge.sv
// Self-checking bench for apb_req_bridge: directed and randomized transfers
// against a transaction-level reference of latency, error and read data.
module tb_apb_req_bridge;

  localparam int unsigned TO = 4;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  prot;
  } req_t;

  typedef struct {
    int unsigned lat;
    bit          err;
    logic [31:0] rdata;
    int unsigned apb_cyc;
    bit          ctrl_ok;
    bit          seq_ok;
    bit          hold_ok;
    bit          psel_at_rsp;
    bit          tmo;
    int unsigned setup_cyc;
    int unsigned hs_edge;
  } txn_obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_req_bridge_if rq ();
  apb_if            ab ();

  apb_req_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clock (clk),
    .reset (rst),
    .req   (rq),
    .apb   (ab)
  );

  // Transaction-level expectation: n wait cycles, timeout once n exceeds TO.
  function automatic void ref_model(input bit wr, input int unsigned nwait, input bit slverr,
                                    input logic [31:0] prd, output int unsigned lat,
                                    output bit err, output logic [31:0] rdata);
    bit to;
    to    = (nwait > TO);
    lat   = to ? 3 + TO : 3 + nwait;
    err   = to | slverr;
    rdata = (to || wr || slverr) ? 32'h0 : prd;
  endfunction

  task automatic apb_junk();
    ab.out_pready  = 1'($urandom);
    ab.out_prdata  = $urandom;
    ab.out_pslverr = 1'($urandom);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.addr  = $urandom;
    r.wr    = 1'($urandom);
    r.wdata = $urandom;
    r.wstrb = 4'($urandom);
    r.prot  = 3'($urandom);
    return r;
  endfunction

  task automatic drive_req(input req_t r);
    rq.req_valid = 1'b1;
    rq.req_addr  = r.addr;
    rq.req_write = r.wr;
    rq.req_wdata = r.wdata;
    rq.req_wstrb = r.wstrb;
    rq.req_prot  = r.prot;
  endtask

  // Drives one transfer and records what the DUT did; called at a negedge.
  task automatic run_txn(input req_t r, input int unsigned nwait, input logic [31:0] prd,
                         input bit slverr, input int unsigned hold, input bit q_next,
                         input req_t nxt, output txn_obs_t o);
    int unsigned guard = 0;
    int unsigned j = 0;
    int unsigned ka;
    bit seen = 0;
    o = '{default: 0};
    o.ctrl_ok = 1; o.seq_ok = 1; o.hold_ok = 1;
    drive_req(r);
    while (rq.req_ready !== 1'b1) begin
      apb_junk();
      guard++;
      if (guard > 40) begin o.tmo = 1; rq.req_valid = 1'b0; return; end
      @(negedge clk);
    end
    ka = cyc + 1;
    apb_junk();
    @(negedge clk);
    rq.req_valid = 1'b0;
    guard = 0;
    while (rq.rsp_valid !== 1'b1) begin
      if (ab.out_psel === 1'b1) begin
        o.apb_cyc++;
        if (!seen) begin
          seen = 1;
          o.setup_cyc = cyc;
          if (ab.out_penable !== 1'b0) o.seq_ok = 0;
        end else if (ab.out_penable !== 1'b1) o.seq_ok = 0;
        if ({ab.out_paddr, ab.out_pwrite, ab.out_pwdata, ab.out_pstrb, ab.out_pprot} !==
            {r.addr, r.wr, r.wdata, (r.wr ? r.wstrb : 4'h0), r.prot}) o.ctrl_ok = 0;
      end
      if (ab.out_psel === 1'b1 && ab.out_penable === 1'b1) begin
        ab.out_pready  = (j == nwait);
        ab.out_prdata  = (j == nwait) ? prd : $urandom;
        ab.out_pslverr = (j == nwait) ? slverr : 1'($urandom);
        j++;
      end else apb_junk();
      guard++;
      if (guard > 60) begin o.tmo = 1; return; end
      @(negedge clk);
    end
    o.lat         = cyc + 1 - ka;
    o.err         = rq.rsp_err;
    o.rdata       = rq.rsp_rdata;
    o.psel_at_rsp = ab.out_psel;
    for (int unsigned h = 0; h <= hold; h++) begin
      if (h == 0 && q_next) drive_req(nxt);
      if ({rq.rsp_valid, rq.rsp_err, rq.rsp_rdata, rq.req_ready} !== {1'b1, o.err, o.rdata, 1'b0})
        o.hold_ok = 0;
      apb_junk();
      if (h == hold) begin
        rq.rsp_ready = 1'b1;
        o.hs_edge    = cyc + 1;
      end
      @(negedge clk);
    end
    rq.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ab.out_psel, ab.out_penable, rq.rsp_valid, rq.req_ready, rq.rsp_err, ab.out_pwrite} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: psel/pen/rsp_valid/req_ready/err/pwrite got %b%b%b%b%b%b want 000000",
               ab.out_psel, ab.out_penable, rq.rsp_valid, rq.req_ready, rq.rsp_err, ab.out_pwrite);
    end
    n_vec++;
    if ({ab.out_paddr, ab.out_pwdata, ab.out_pstrb, ab.out_pprot, rq.rsp_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: paddr %h pwdata %h pstrb %h pprot %h rdata %h want all 0",
               ab.out_paddr, ab.out_pwdata, ab.out_pstrb, ab.out_pprot, rq.rsp_rdata);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (rq.req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b want 1", rq.req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_one(input string name, input req_t r, input int unsigned nwait,
                          input logic [31:0] prd, input bit slverr, input int unsigned hold);
    txn_obs_t o; int unsigned el; bit ee; logic [31:0] ed;
    run_txn(r, nwait, prd, slverr, hold, 1'b0, r, o);
    ref_model(r.wr, nwait, slverr, prd, el, ee, ed);
    n_vec++;
    if ({o.lat, o.err, o.rdata} !== {el, ee, ed}) begin
      n_err++;
      $display("FAIL %s rsp: lat/err/rdata got %0d/%0d/%h want %0d/%0d/%h",
               name, o.lat, o.err, o.rdata, el, ee, ed);
    end
    n_vec++;
    if ({o.ctrl_ok, o.seq_ok, o.hold_ok, o.apb_cyc, o.psel_at_rsp} !== {3'b111, el - 1, 1'b0}) begin
      n_err++;
      $display("FAIL %s apb: ctrl/seq/hold/cycles/psel_at_rsp got %b/%b/%b/%0d/%b want 1/1/1/%0d/0",
               name, o.ctrl_ok, o.seq_ok, o.hold_ok, o.apb_cyc, o.psel_at_rsp, el - 1);
    end
  endtask

  task automatic test_write_zero_wait();
    req_t r;
    r = '{addr: 32'h1000_0000, wr: 1'b1, wdata: 32'hDEAD_BEEF, wstrb: 4'hF, prot: 3'($urandom)};
    test_one("write_zero_wait", r, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_read_wait3();
    req_t r;
    r = rand_req();
    r.wr = 1'b0;
    test_one("read_wait3", r, 3, 32'h0000_A5A5, 1'b0, 1);
  endtask

  task automatic test_slverr();
    req_t r;
    r = rand_req();
    r.wr = 1'b0;
    test_one("slverr_read", r, 1, $urandom, 1'b1, 0);
    r = rand_req();
    r.wr = 1'b1;
    test_one("slverr_write", r, 0, $urandom, 1'b1, 0);
  endtask

  task automatic test_timeout();
    test_one("timeout_stuck", rand_req(), 1000, $urandom, 1'b0, 0);
    test_one("timeout_edge_ok", rand_req(), TO, $urandom, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    req_t r1, r2; txn_obs_t o1, o2; int unsigned el; bit ee; logic [31:0] ed;
    r1 = rand_req();
    r1.wr = 1'b0;
    r2 = rand_req();
    run_txn(r1, 0, 32'h1234_5678, 1'b0, 5, 1'b1, r2, o1);
    ref_model(r1.wr, 0, 1'b0, 32'h1234_5678, el, ee, ed);
    n_vec++;
    if ({o1.lat, o1.err, o1.rdata, o1.hold_ok} !== {el, ee, ed, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_first: lat/err/rdata/hold_ok got %0d/%0d/%h/%b want %0d/%0d/%h/1",
               o1.lat, o1.err, o1.rdata, o1.hold_ok, el, ee, ed);
    end
    run_txn(r2, 2, 32'h0BAD_F00D, 1'b0, 0, 1'b0, r2, o2);
    ref_model(r2.wr, 2, 1'b0, 32'h0BAD_F00D, el, ee, ed);
    n_vec++;
    if (o2.setup_cyc + 1 - o1.hs_edge !== 2) begin
      n_err++;
      $display("FAIL b2b_gap: setup after handshake edge got %0d want 2", o2.setup_cyc + 1 - o1.hs_edge);
    end
    n_vec++;
    if ({o2.lat, o2.err, o2.rdata, o2.ctrl_ok, o2.seq_ok} !== {el, ee, ed, 2'b11}) begin
      n_err++;
      $display("FAIL b2b_second: lat/err/rdata/ctrl/seq got %0d/%0d/%h/%b/%b want %0d/%0d/%h/1/1",
               o2.lat, o2.err, o2.rdata, o2.ctrl_ok, o2.seq_ok, el, ee, ed);
    end
  endtask

  task automatic test_reset_mid_access();
    int unsigned guard = 0;
    bit quiet = 1;
    drive_req(rand_req());
    while (!(ab.out_psel === 1'b1 && ab.out_penable === 1'b1) && guard < 20) begin
      if (rq.req_ready === 1'b1) begin
        @(negedge clk);
        rq.req_valid = 1'b0;
      end else @(negedge clk);
      ab.out_pready = 1'b0;
      guard++;
    end
    rq.req_valid = 1'b0;
    n_vec++;
    if (guard >= 20) begin
      n_err++;
      $display("FAIL rst_mid_reach_access: got no ACCESS within %0d cycles want ACCESS", guard);
    end
    ab.out_pready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({ab.out_psel, ab.out_penable, rq.rsp_valid, rq.req_ready} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: psel/pen/rsp_valid/req_ready got %b%b%b%b want 0000",
               ab.out_psel, ab.out_penable, rq.rsp_valid, rq.req_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      apb_junk();
      @(negedge clk);
      if (rq.rsp_valid !== 1'b0 || ab.out_psel !== 1'b0 || rq.req_ready !== 1'b1) quiet = 0;
    end
    n_vec++;
    if (quiet !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_no_response: quiet got %b want 1", quiet);
    end
    test_one("rst_mid_fresh", rand_req(), 1, $urandom, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      test_one($sformatf("rand[%0d]", i), rand_req(), $urandom_range(0, 6), $urandom,
               ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rq.req_valid = 1'b0; rq.req_addr = '0; rq.req_write = 1'b0; rq.req_wdata = '0;
    rq.req_wstrb = '0; rq.req_prot = '0; rq.rsp_ready = 1'b0;
    ab.out_pready = 1'b0; ab.out_prdata = '0; ab.out_pslverr = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
